// File: rtl/bsa_defs.sv
`default_nettype none
// ============================================================================
//  Module      : bsa_defs (package)
//  Description : Shared definitions for the bit-serial adder: FSM state
//                encoding and the bit-counter width helper.
//  Contents    : state_t   - IDLE / SHIFT / DONE encoding (2 bits)
//                cnt_width - max(1, clog2(w)) bit-counter width
//  Revision    : 1.0 - initial release
// ============================================================================
package bsa_defs;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // A 1-bit adder still needs a 1-bit counter, so clamp clog2 at one.
  function automatic int cnt_width(input int w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

endpackage
`default_nettype wire

// File: rtl/full_adder_cell.sv
`default_nettype none
// ============================================================================
//  Module      : full_adder_cell
//  Description : One-bit full adder built from two half-adder stages with an
//                OR merging the two stage carries.
//  Ports       : a, b, ci - addend bits and carry-in
//                s        - sum bit
//                co       - carry-out
//  Revision    : 1.0 - initial release
// ============================================================================
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic w_p;   // first half adder: propagate
  logic w_g1;  // first half adder: generate
  logic w_g2;  // second half adder: carry

  assign w_p  = a ^ b;
  assign w_g1 = a & b;
  assign s    = w_p ^ ci;
  assign w_g2 = w_p & ci;
  assign co   = w_g1 | w_g2;

endmodule
`default_nettype wire

// File: rtl/bit_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : bit_serial_adder
//  Description : LSB-first bit-serial adder. Operands and carry-in are taken
//                through a valid/ready handshake, shifted through a single
//                full-adder cell (one bit per clock, registered carry), and
//                the WIDTH-bit sum plus carry-out are offered through a
//                second valid/ready handshake.
//  Parameters  : WIDTH     - operand / sum width, 1..32
//  Ports       : clk       - rising-edge clock
//                rst       - asynchronous active-high reset
//                in_valid  / in_ready  - operand handshake (a, b, cin)
//                out_valid / out_ready - result handshake (sum, cout)
//                sum       - a + b + cin modulo 2^WIDTH
//                cout      - carry-out of the WIDTH-bit addition
//  Revision    : 1.0 - initial release
// ============================================================================
module bit_serial_adder
  import bsa_defs::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int             c_cnt_w    = cnt_width(WIDTH);
  localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(WIDTH - 1);

  state_t               r_state;
  state_t               w_state_nxt;

  logic [WIDTH-1:0]     r_a_sh;
  logic [WIDTH-1:0]     r_b_sh;
  logic [WIDTH-1:0]     r_sum_sh;
  logic                 r_carry;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [WIDTH-1:0]     r_sum;
  logic                 r_cout;

  logic                 w_s;
  logic                 w_co;
  logic                 w_accept;
  logic                 w_last;
  logic [WIDTH:0]       w_sum_full;
  logic [WIDTH-1:0]     w_sum_nxt;
  logic                 w_unused_lsb;

  full_adder_cell u_fa (
    .a  (r_a_sh[0]),
    .b  (r_b_sh[0]),
    .ci (r_carry),
    .s  (w_s),
    .co (w_co)
  );

  // New sum bit enters at the MSB; the old LSB falls off. After WIDTH shifts
  // the first (LSB) sum bit has walked all the way down to bit 0.
  assign w_sum_full   = {w_s, r_sum_sh};
  assign w_sum_nxt    = w_sum_full[WIDTH:1];
  assign w_unused_lsb = w_sum_full[0];

  assign w_accept = in_valid & in_ready;
  assign w_last   = (r_cnt == c_last_cnt);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and handshake outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Held low while rst is asserted so a handshake never wins over reset.
        in_ready = ~rst;
        if (in_valid && !rst) begin
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_last) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: shift registers, carry, bit counter and result registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_sum_sh <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
    end else if (w_accept) begin
      r_a_sh   <= a;
      r_b_sh   <= b;
      r_carry  <= cin;
      r_sum_sh <= '0;
      r_cnt    <= '0;
    end else if (r_state == ST_SHIFT) begin
      r_carry  <= w_co;
      r_sum_sh <= w_sum_nxt;
      r_a_sh   <= r_a_sh >> 1;
      r_b_sh   <= r_b_sh >> 1;
      if (w_last) begin
        // Result registers only change on DONE entry, so sum/cout keep the
        // previous result through IDLE and the next SHIFT phase.
        r_sum  <= w_sum_nxt;
        r_cout <= w_co;
      end else begin
        r_cnt  <= r_cnt + c_cnt_w'(1);
      end
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_bit_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bit_serial_adder
//  Description : Self-checking bench for bit_serial_adder. An 8-bit instance
//                covers directed, backpressure, reset-abort and random
//                back-to-back traffic through an expected-result queue; a
//                1-bit instance covers the single-cycle SHIFT case.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bit_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  always #5 clk = ~clk;

  // 8-bit instance
  logic         in_valid, in_ready, out_valid, out_ready, cin, cout;
  logic [W-1:0] a, b, sum;

  // 1-bit instance
  logic         d1_in_valid, d1_in_ready, d1_out_valid, d1_out_ready;
  logic         d1_cin, d1_cout;
  logic [0:0]   d1_a, d1_b, d1_sum;

  int           n_vec = 0;
  int           n_err = 0;
  int           cyc   = 0;
  int           acc_cyc;
  logic [W:0]   q_exp[$];

  always @(posedge clk) cyc <= cyc + 1;

  bit_serial_adder #(.WIDTH(W)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  bit_serial_adder #(.WIDTH(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (d1_in_valid),
    .in_ready  (d1_in_ready),
    .a         (d1_a),
    .b         (d1_b),
    .cin       (d1_cin),
    .out_valid (d1_out_valid),
    .out_ready (d1_out_ready),
    .sum       (d1_sum),
    .cout      (d1_cout)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  // Result monitor: the handshake completes on the following rising edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q_exp.size() == 0) begin
        check("sb_underflow", 64'd1, 64'd0);
      end else begin
        check("result", {cout, sum}, q_exp.pop_front());
      end
    end
  end

  // Present operands and wait for the acceptance edge; leaves in_valid high
  // afterwards when hold is set.
  task automatic send8(input logic [W-1:0] sa, input logic [W-1:0] sb_, input logic sc,
                       input bit hold);
    int k;
    a = sa; b = sb_; cin = sc; in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 100) begin
      @(posedge clk); #1; k++;
    end
    if (!in_ready) check("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    q_exp.push_back(model(sa, sb_, sc));
    #1;
    acc_cyc = cyc;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!out_valid && k < 100) begin
      @(posedge clk); #1; k++;
    end
    if (!out_valid) check("done_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic op8(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic oc,
                     input logic [W-1:0] es, input logic ec, input string tag);
    int lat;
    send8(oa, ob, oc, 1'b0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    check({tag, "_lat"},  lat,  W);
    check({tag, "_sum"},  sum,  es);
    check({tag, "_cout"}, cout, ec);
    @(posedge clk); #1;
    check({tag, "_idle"}, in_ready, 1);
  endtask

  task automatic op1(input logic oa, input logic ob, input logic oc,
                     input logic es, input logic ec, input string tag);
    int k;
    d1_a = oa; d1_b = ob; d1_cin = oc; d1_in_valid = 1'b1;
    k = 0;
    while (!d1_in_ready && k < 20) begin
      @(posedge clk); #1; k++;
    end
    if (!d1_in_ready) check({tag, "_accept_timeout"}, 64'd0, 64'd1);
    @(posedge clk); #1;
    d1_in_valid = 1'b0;
    k = 0;
    while (!d1_out_valid && k < 20) begin
      @(posedge clk); #1; k++;
    end
    check({tag, "_lat"},  k,       1);
    check({tag, "_sum"},  d1_sum,  es);
    check({tag, "_cout"}, d1_cout, ec);
    @(posedge clk); #1;
  endtask

  initial begin
    int k;
    int prev;
    logic [W-1:0] ra, rb;
    logic         rc;

    rst = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
    d1_in_valid = 1'b0; d1_a = '0; d1_b = '0; d1_cin = 1'b0; d1_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_sum",       sum,       0);
    check("rst_cout",      cout,      0);
    check("rst_d1_valid",  d1_out_valid, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_in_ready", in_ready, 1);

    // Directed sums
    op8(8'h5A, 8'h33, 1'b0, 8'h8D, 1'b1 & 1'b0, "t1");
    op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "t2a");
    op8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "t2b");

    // Backpressure: result held while new operands wiggle at the input
    out_ready = 1'b0;
    send8(8'hC3, 8'h5A, 1'b1, 1'b0);
    k = 0;
    while (!out_valid && k < 40) begin
      @(posedge clk); #1; k++;
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      @(posedge clk); #1;
      check("bp_valid",    out_valid, 1);
      check("bp_in_ready", in_ready,  0);
      check("bp_sum",      sum,       8'h1E);
      check("bp_cout",     cout,      1);
    end
    a = 8'h12; b = 8'h34; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_ready", in_ready,  1);
    check("bp_release_valid", out_valid, 0);
    @(posedge clk);
    q_exp.push_back(model(8'h12, 8'h34, 1'b0));
    #1;
    in_valid = 1'b0;
    check("bp_accepted", in_ready, 0);
    wait_done();
    check("bp_pending_sum", sum, 8'h46);

    // Reset in the middle of bit 3
    send8(8'hF0, 8'h0F, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_sum",   sum,       0);
    check("mid_rst_cout",  cout,      0);
    q_exp.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    op8(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, "t4");

    // Single-bit instance
    op1(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, "w1a");
    op1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "w1b");
    op1(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "w1c");

    // Random back-to-back with in_valid held high
    out_ready = 1'b1;
    prev = 0;
    for (int n = 0; n < 1000; n++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      send8(ra, rb, rc, 1'b1);
      if (n > 0) check("spacing", acc_cyc - prev, W + 2);
      prev = acc_cyc;
    end
    in_valid = 1'b0;
    wait_done();
    @(posedge clk); #1;
    check("sb_drain", q_exp.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
